seven_seg_reader: RTL and testbench

Sequential capture/decode block for a multiplexed, active-low seven-segment display bus: the inverse of the team's hex-to-segment decoder. It watches the segment lines and active-low digit strobes, waits for each digit's pattern to be stable, and maps each pattern back to a 4-bit nibble. When every digit position has been captured it publishes one hex word. It sits on the board-test and self-check path, observing the same segment/anode nets that drive the display.

---
 rtl/seven_seg_pkg.sv | 33 +++
 rtl/seg_to_hex.sv | 38 +++
 rtl/seven_seg_reader.sv | 139 +++++++++++++
 tb/tb_seven_seg_reader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared seven-segment glyph constants (active-low, seg[0]=a .. seg[6]=g).
// Used by both the hex-to-segment decoder and the segment reader.
package seven_seg_pkg;

    localparam int SEG_W = 7;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [SEG_W-1:0] SEG_HEX_0 = 7'h40;
    localparam logic [SEG_W-1:0] SEG_HEX_1 = 7'h79;
    localparam logic [SEG_W-1:0] SEG_HEX_2 = 7'h24;
    localparam logic [SEG_W-1:0] SEG_HEX_3 = 7'h30;
    localparam logic [SEG_W-1:0] SEG_HEX_4 = 7'h19;
    localparam logic [SEG_W-1:0] SEG_HEX_5 = 7'h12;
    localparam logic [SEG_W-1:0] SEG_HEX_6 = 7'h02;
    localparam logic [SEG_W-1:0] SEG_HEX_7 = 7'h78;
    localparam logic [SEG_W-1:0] SEG_HEX_8 = 7'h00;
    localparam logic [SEG_W-1:0] SEG_HEX_9 = 7'h10;
    localparam logic [SEG_W-1:0] SEG_HEX_A = 7'h08;
    localparam logic [SEG_W-1:0] SEG_HEX_B = 7'h03;
    localparam logic [SEG_W-1:0] SEG_HEX_C = 7'h46;
    localparam logic [SEG_W-1:0] SEG_HEX_D = 7'h21;
    localparam logic [SEG_W-1:0] SEG_HEX_E = 7'h06;
    localparam logic [SEG_W-1:0] SEG_HEX_F = 7'h0E;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg_to_hex.sv
// Combinational inverse glyph lookup: active-low segment pattern to nibble.
// Blank and illegal patterns both report nibble 0 with their own flag.
module seg_to_hex
    import seven_seg_pkg::*;
(
    input  logic [SEG_W-1:0] seg_i,
    output logic [3:0]       nibble_o,
    output logic             blank_o,
    output logic             err_o
);

    always_comb begin
        nibble_o = 4'h0;
        blank_o  = 1'b0;
        err_o    = 1'b0;
        case (seg_i)
            SEG_HEX_0: nibble_o = 4'h0;
            SEG_HEX_1: nibble_o = 4'h1;
            SEG_HEX_2: nibble_o = 4'h2;
            SEG_HEX_3: nibble_o = 4'h3;
            SEG_HEX_4: nibble_o = 4'h4;
            SEG_HEX_5: nibble_o = 4'h5;
            SEG_HEX_6: nibble_o = 4'h6;
            SEG_HEX_7: nibble_o = 4'h7;
            SEG_HEX_8: nibble_o = 4'h8;
            SEG_HEX_9: nibble_o = 4'h9;
            SEG_HEX_A: nibble_o = 4'hA;
            SEG_HEX_B: nibble_o = 4'hB;
            SEG_HEX_C: nibble_o = 4'hC;
            SEG_HEX_D: nibble_o = 4'hD;
            SEG_HEX_E: nibble_o = 4'hE;
            SEG_HEX_F: nibble_o = 4'hF;
            SEG_BLANK: blank_o  = 1'b1;
            default:   err_o    = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_seg_reader.sv
// Captures stable digits from a multiplexed active-low seven-segment bus and
// publishes one hex word once every digit position has been seen.
module seven_seg_reader
    import seven_seg_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SEG_W-1:0]      seg,
    input  logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     digit_err,
    output logic [DIGITS-1:0]     blank,
    output logic                  frame_valid
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [SEG_W-1:0]    seg_q, seg_prev_q;
    logic [DIGITS-1:0]   an_q, an_prev_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;
    logic [4*DIGITS-1:0] stg_val_q, stg_val_d;
    logic [DIGITS-1:0]   stg_err_q, stg_err_d;
    logic [DIGITS-1:0]   stg_blank_q, stg_blank_d;
    logic [DIGITS-1:0]   mask_q, mask_d;
    logic [4*DIGITS-1:0] value_q, value_d;
    logic [DIGITS-1:0]   err_q, err_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic                fv_q;

    logic [DIGITS-1:0]   low;
    logic                onehot;
    logic                changed;
    logic                capture;
    logic                complete;
    logic [IDX_W-1:0]    idx;
    logic [3:0]          dec_nib;
    logic                dec_blank;
    logic                dec_err;

    seg_to_hex u_dec (
        .seg_i    (seg_q),
        .nibble_o (dec_nib),
        .blank_o  (dec_blank),
        .err_o    (dec_err)
    );

    always_comb begin
        low     = ~an_q;
        onehot  = (low != '0) && ((low & (low - DIGITS'(1))) == '0);
        changed = (seg_q != seg_prev_q) || (an_q != an_prev_q);
        idx     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (low[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    // A changed sample is the first of a new run, so it counts as one;
    // done from the previous run never blocks the new one.
    always_comb begin
        cnt_d = '0;
        if (onehot) begin
            if (changed) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q == CNT_MAX) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        capture = onehot && (cnt_d == CNT_MAX) && (changed || !done_q);
        done_d  = onehot && (capture || (!changed && done_q));
    end

    always_comb begin
        complete    = &mask_q;
        mask_d      = complete ? '0 : mask_q;
        stg_val_d   = stg_val_q;
        stg_err_d   = stg_err_q;
        stg_blank_d = stg_blank_q;
        if (capture) begin
            mask_d[idx]                  = 1'b1;
            stg_val_d[4*int'(idx) +: 4]  = dec_nib;
            stg_err_d[idx]               = dec_err;
            stg_blank_d[idx]             = dec_blank;
        end
        // The completing copy takes staging as it was before this edge's write.
        value_d = complete ? stg_val_q   : value_q;
        err_d   = complete ? stg_err_q   : err_q;
        blank_d = complete ? stg_blank_q : blank_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q       <= SEG_BLANK;
            seg_prev_q  <= SEG_BLANK;
            an_q        <= '1;
            an_prev_q   <= '1;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            stg_val_q   <= '0;
            stg_err_q   <= '0;
            stg_blank_q <= '0;
            mask_q      <= '0;
            value_q     <= '0;
            err_q       <= '0;
            blank_q     <= '0;
            fv_q        <= 1'b0;
        end else begin
            seg_q       <= seg;
            an_q        <= an;
            seg_prev_q  <= seg_q;
            an_prev_q   <= an_q;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            stg_val_q   <= stg_val_d;
            stg_err_q   <= stg_err_d;
            stg_blank_q <= stg_blank_d;
            mask_q      <= mask_d;
            value_q     <= value_d;
            err_q       <= err_d;
            blank_q     <= blank_d;
            fv_q        <= complete;
        end
    end

    assign value       = value_q;
    assign digit_err   = err_q;
    assign blank       = blank_q;
    assign frame_valid = fv_q;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Bench for seven_seg_reader: directed frame table, reset sequence and
// random strobe traffic checked cycle by cycle against a pin-level model.
module tb_seven_seg_reader;

    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  an_r;
    logic [6:0]  seg_r;
    logic [15:0] value;
    logic [3:0]  digit_err;
    logic [3:0]  blank;
    logic        frame_valid;

    always #5 clk = ~clk;

    seven_seg_reader #(.DIGITS(4), .STABLE_CYCLES(STABLE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg_r),
        .an          (an_r),
        .value       (value),
        .digit_err   (digit_err),
        .blank       (blank),
        .frame_valid (frame_valid)
    );

    int vectors = 0;
    int miscompares = 0;
    int fv_seen, cur_run, max_run;

    logic [6:0] glyph [16];

    // Reference model state
    logic [10:0] hist [$];
    logic [15:0] m_stg_val, m_val;
    logic [3:0]  m_stg_err, m_stg_blk, m_err, m_blk, m_mask;
    logic        m_fv;

    typedef struct packed {
        logic [3:0]       nsteps;
        logic [7:0][3:0]  an;
        logic [7:0][6:0]  sg;
        logic [7:0][3:0]  hold;
        logic [1:0]       fv;
        logic [15:0]      val;
        logic [3:0]       err;
        logic [3:0]       blk;
    } row_t;

    row_t rows [6];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    function automatic void decode(input logic [6:0] s, output logic [3:0] nib,
                                   output logic e, output logic b);
        nib = 4'h0;
        e   = 1'b1;
        b   = 1'b0;
        if (s == 7'h7F) begin
            e = 1'b0;
            b = 1'b1;
        end else begin
            for (int k = 0; k < 16; k++) begin
                if (glyph[k] == s) begin
                    nib = k[3:0];
                    e   = 1'b0;
                end
            end
        end
    endfunction

    task automatic model_reset();
        hist.delete();
        m_stg_val = '0; m_stg_err = '0; m_stg_blk = '0; m_mask = '0;
        m_val = '0; m_err = '0; m_blk = '0; m_fv = 1'b0;
    endtask

    // One clock edge: pins sampled at earlier edges decide captures now.
    task automatic model_edge(input logic [3:0] a, input logic [6:0] s);
        int n;
        int pos;
        logic [10:0] last;
        logic [3:0] nib;
        logic e, b;
        m_fv = 1'b0;
        if (m_mask == 4'hF) begin
            m_val = m_stg_val; m_err = m_stg_err; m_blk = m_stg_blk;
            m_fv = 1'b1;
            m_mask = 4'h0;
        end
        n = 0;
        last = '0;
        if (hist.size() > 0) begin
            last = hist[hist.size()-1];
            if ($countones(~last[10:7]) == 1) begin
                for (int i = hist.size() - 1; i >= 0; i--) begin
                    if (hist[i] != last) break;
                    n++;
                end
            end
        end
        if (n == STABLE) begin
            decode(last[6:0], nib, e, b);
            pos = 0;
            for (int i = 0; i < 4; i++) if (!last[7+i]) pos = i;
            m_stg_val[pos*4 +: 4] = nib;
            m_stg_err[pos] = e;
            m_stg_blk[pos] = b;
            m_mask[pos] = 1'b1;
        end
        hist.push_back({a, s});
        if (hist.size() > STABLE + 1) void'(hist.pop_front());
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge(an_r, seg_r);
        #1;
        vectors++;
        if ({value, digit_err, blank, frame_valid} !== {m_val, m_err, m_blk, m_fv}) begin
            miscompares++;
            $display("FAIL cycle t=%0t: got val=%h err=%b blk=%b fv=%b want val=%h err=%b blk=%b fv=%b",
                     $time, value, digit_err, blank, frame_valid, m_val, m_err, m_blk, m_fv);
        end
        if (frame_valid) begin
            fv_seen++;
            cur_run++;
            if (cur_run > max_run) max_run = cur_run;
        end else begin
            cur_run = 0;
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
        an_r  = a;
        seg_r = s;
        repeat (n) step();
    endtask

    task automatic add_step(input int r, input logic [3:0] a, input logic [6:0] s, input int h);
        rows[r].an[rows[r].nsteps]   = a;
        rows[r].sg[rows[r].nsteps]   = s;
        rows[r].hold[rows[r].nsteps] = 4'(h);
        rows[r].nsteps = rows[r].nsteps + 4'd1;
    endtask

    task automatic set_exp(input int r, input int fv, input logic [15:0] v,
                           input logic [3:0] e, input logic [3:0] b);
        rows[r].fv  = 2'(fv);
        rows[r].val = v;
        rows[r].err = e;
        rows[r].blk = b;
    endtask

    initial begin
        int sel, h;
        logic [3:0] a;
        logic [6:0] s;

        glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        for (int r = 0; r < 6; r++) rows[r] = '0;
        add_step(0, 4'hE, 7'h40, 6); add_step(0, 4'hD, 7'h79, 6);
        add_step(0, 4'hB, 7'h24, 6); add_step(0, 4'h7, 7'h30, 6);
        set_exp(0, 1, 16'h3210, 4'h0, 4'h0);
        add_step(1, 4'hE, 7'h40, 6); add_step(1, 4'hD, 7'h79, 6);
        add_step(1, 4'hB, 7'h24, 3); add_step(1, 4'h7, 7'h30, 6);
        set_exp(1, 0, 16'h3210, 4'h0, 4'h0);
        add_step(2, 4'hB, 7'h24, 6);
        set_exp(2, 1, 16'h3210, 4'h0, 4'h0);
        add_step(3, 4'hE, 7'h40, 6); add_step(3, 4'hD, 7'h7F, 6);
        add_step(3, 4'hB, 7'h24, 6); add_step(3, 4'h7, 7'h55, 6);
        set_exp(3, 1, 16'h0200, 4'b1000, 4'b0010);
        add_step(4, 4'hE, 7'h40, 6);  add_step(4, 4'hC, 7'h08, 10);
        add_step(4, 4'hD, 7'h79, 6);  add_step(4, 4'hF, 7'h7F, 10);
        add_step(4, 4'hB, 7'h24, 6);  add_step(4, 4'h7, 7'h30, 6);
        set_exp(4, 1, 16'h3210, 4'h0, 4'h0);
        for (int k = 0; k < 2; k++) begin
            add_step(5, 4'hE, 7'h08, 4); add_step(5, 4'hD, 7'h03, 4);
            add_step(5, 4'hB, 7'h46, 4); add_step(5, 4'h7, 7'h21, 4);
        end
        set_exp(5, 2, 16'hDCBA, 4'h0, 4'h0);

        rst_n = 1'b0;
        an_r  = 4'hF;
        seg_r = 7'h7F;
        model_reset();
        fv_seen = 0; cur_run = 0; max_run = 0;
        repeat (2) step();
        check("reset value", 32'(value), 32'h0);
        check("reset err_blank_fv", {23'd0, digit_err, blank, frame_valid}, 32'h0);
        rst_n = 1'b1;
        drive(4'hF, 7'h7F, 2);

        for (int r = 0; r < 6; r++) begin
            fv_seen = 0; cur_run = 0; max_run = 0;
            for (int i = 0; i < int'(rows[r].nsteps); i++)
                drive(rows[r].an[i], rows[r].sg[i], int'(rows[r].hold[i]));
            drive(4'hF, 7'h7F, 3);
            check($sformatf("row%0d fv_count", r), 32'(fv_seen), 32'(rows[r].fv));
            check($sformatf("row%0d pulse_width", r), 32'(max_run), (rows[r].fv != 0) ? 32'd1 : 32'd0);
            check($sformatf("row%0d value", r), 32'(value), 32'(rows[r].val));
            check($sformatf("row%0d digit_err", r), 32'(digit_err), 32'(rows[r].err));
            check($sformatf("row%0d blank", r), 32'(blank), 32'(rows[r].blk));
        end

        // Reset in the middle of a frame: partial frame must be discarded.
        drive(4'hE, 7'h40, 6);
        drive(4'hD, 7'h79, 6);
        drive(4'hB, 7'h24, 6);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async reset outputs", {11'd0, value, digit_err, blank, frame_valid}, 32'h0);
        drive(4'hF, 7'h7F, 2);
        rst_n = 1'b1;
        fv_seen = 0; cur_run = 0; max_run = 0;
        drive(4'h7, 7'h30, 6);
        drive(4'hF, 7'h7F, 3);
        check("post-reset fv_count", 32'(fv_seen), 32'd0);
        check("post-reset outputs", {11'd0, value, digit_err, blank, frame_valid}, 32'h0);

        for (int r = 0; r < 250; r++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7) a = ~(4'b0001 << $urandom_range(0, 3));
            else if (sel == 7) a = 4'hF;
            else a = 4'($urandom);
            if ($urandom_range(0, 5) == 0) s = 7'($urandom);
            else if ($urandom_range(0, 9) == 0) s = 7'h7F;
            else s = glyph[$urandom_range(0, 15)];
            h = (sel < 7 && $urandom_range(0, 3) != 0) ? $urandom_range(4, 7) : $urandom_range(1, 3);
            drive(a, s, h);
        end
        drive(4'hF, 7'h7F, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
